// File: rtl/lobster_lsu.sv
// lobster_lsu: in-order load/store unit. Buffers executor memory requests in a small
// queue, issues them as single-beat 64-bit memory transactions and writes back loads.
module lobster_lsu #(
    parameter int ADDR_WIDTH  = 36,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_load,
    input  logic [1:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [6:0]            req_rd,
    input  logic [127:0]          req_wdata,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [63:0]           mem_wdata,
    output logic [7:0]            mem_wmask,
    input  logic                  mem_rvalid,
    input  logic [63:0]           mem_rdata,
    output logic                  wb_valid,
    output logic [6:0]            wb_select,
    output logic [127:0]          wb_value,
    output logic                  err,
    output logic                  busy
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R} state_t;

    // Byte-enable pattern of an access of the given size, positioned at lane 0.
    function automatic logic [7:0] size_bytes(input logic [1:0] size);
        case (size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [63:0] extract_load(input logic [63:0] rdata,
                                                 input logic [2:0]  lane,
                                                 input logic [1:0]  size);
        logic [63:0] shifted;
        logic [7:0]  be;
        shifted = rdata >> {lane, 3'b000};
        be      = size_bytes(size);
        for (int i = 0; i < 8; i++) begin
            if (!be[i]) shifted[8*i +: 8] = 8'h00;
        end
        return shifted;
    endfunction

    logic                  q_load  [QUEUE_DEPTH];
    logic [1:0]            q_size  [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_addr  [QUEUE_DEPTH];
    logic [6:0]            q_rd    [QUEUE_DEPTH];
    logic [63:0]           q_wdata [QUEUE_DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    state_t           state;

    logic [2:0] cur_lane;
    logic [1:0] cur_size;
    logic [6:0] cur_rd;
    logic       cur_load;

    logic                  accept, misaligned, push, pop;
    logic                  head_load;
    logic [1:0]            head_size;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [6:0]            head_rd;
    logic [63:0]           head_wdata;
    logic                  unused_wdata_hi;

    assign req_ready  = (count != CNT_W'(QUEUE_DEPTH));
    assign accept     = req_valid && req_ready;
    assign misaligned = (req_addr[2:0] & align_mask(req_size)) != 3'b000;
    assign push       = accept && !misaligned;
    assign pop        = (state == IDLE) && (count != '0);
    assign busy       = (count != '0) || (state != IDLE);

    assign head_load  = q_load[rd_ptr];
    assign head_size  = q_size[rd_ptr];
    assign head_addr  = q_addr[rd_ptr];
    assign head_rd    = q_rd[rd_ptr];
    assign head_wdata = q_wdata[rd_ptr];

    // The memory port is only 64 bits wide; upper store data is never used.
    assign unused_wdata_hi = ^req_wdata[127:64];

    always_ff @(posedge clk) begin
        if (push) begin
            q_load[wr_ptr]  <= req_load;
            q_size[wr_ptr]  <= req_size;
            q_addr[wr_ptr]  <= req_addr;
            q_rd[wr_ptr]    <= req_rd;
            q_wdata[wr_ptr] <= req_wdata[63:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            err <= accept && misaligned;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Command and writeback outputs are registered straight out of the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            wb_valid  <= 1'b0;
            wb_select <= '0;
            wb_value  <= '0;
            cur_lane  <= '0;
            cur_size  <= '0;
            cur_rd    <= '0;
            cur_load  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_lane  <= head_addr[2:0];
                        cur_size  <= head_size;
                        cur_rd    <= head_rd;
                        cur_load  <= head_load;
                        mem_valid <= 1'b1;
                        mem_we    <= !head_load;
                        mem_addr  <= {head_addr[ADDR_WIDTH-1:3], 3'b000};
                        mem_wmask <= head_load ? 8'h00 : size_bytes(head_size) << head_addr[2:0];
                        mem_wdata <= head_load ? 64'd0 : head_wdata << {head_addr[2:0], 3'b000};
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state     <= cur_load ? WAIT_R : IDLE;
                    end
                end
                WAIT_R: begin
                    if (mem_rvalid) begin
                        wb_valid  <= (cur_rd != 7'd0);
                        wb_select <= cur_rd;
                        wb_value  <= {64'd0, extract_load(mem_rdata, cur_lane, cur_size)};
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lobster_lsu.sv
// Bench for lobster_lsu: directed vector table, multi-cycle corner sequences and a
// randomized run scored against a transaction-level reference model.
module tb_lobster_lsu;
    localparam int AW = 36;
    localparam int QD = 4;
    localparam int NV = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_valid, req_ready, req_load;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [6:0]    req_rd;
    logic [127:0]  req_wdata;
    logic          mem_valid, mem_ready, mem_we;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wdata;
    logic [7:0]    mem_wmask;
    logic          mem_rvalid;
    logic [63:0]   mem_rdata;
    logic          wb_valid;
    logic [6:0]    wb_select;
    logic [127:0]  wb_value;
    logic          err, busy;

    lobster_lsu #(.ADDR_WIDTH(AW), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_size(req_size), .req_addr(req_addr), .req_rd(req_rd), .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_select(wb_select),
        .wb_value(wb_value), .err(err), .busy(busy)
    );

    typedef struct {
        logic          load;
        logic [1:0]    size;
        logic [AW-1:0] addr;
        logic [6:0]    rd;
        logic [127:0]  wdata;
    } txn_t;

    typedef struct {
        logic          load;
        logic [1:0]    size;
        logic [AW-1:0] addr;
        logic [6:0]    rd;
        logic [127:0]  wdata;
        logic [63:0]   rdata;
        logic          exp_err;
        logic [AW-1:0] exp_maddr;
        logic          exp_we;
        logic [7:0]    exp_wmask;
        logic [63:0]   exp_wdata;
        logic          exp_wb;
        logic [127:0]  exp_value;
    } vec_t;

    vec_t vecs [NV];

    int chk_cnt = 0;
    int pass_cnt = 0;

    // Reference model: accepted transactions not yet completed, oldest first.
    txn_t         q [$];
    bit           head_issued = 1'b0;
    bit           err_exp = 1'b0;
    bit           wb_exp_v = 1'b0;
    logic [6:0]   wb_exp_sel = '0;
    logic [127:0] wb_exp_val = '0;
    bit           last_acc = 1'b0;
    int           stores_done = 0;
    int           loads_done = 0;
    int           mem_mode = 2;
    logic [63:0]  dir_rdata = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic bit is_misaligned(input logic [1:0] size, input logic [AW-1:0] addr);
        int nb;
        nb = 1 << size;
        return (int'(addr[2:0]) % nb) != 0;
    endfunction

    function automatic logic [7:0] exp_mask(input logic [1:0] size, input int lane);
        int nb;
        nb = 1 << size;
        return 8'(((1 << nb) - 1) << lane);
    endfunction

    function automatic logic [63:0] exp_wd(input logic [127:0] w, input int lane);
        logic [63:0] lo;
        lo = w[63:0];
        return lo << (8 * lane);
    endfunction

    function automatic logic [127:0] exp_load(input logic [63:0] rdata, input logic [1:0] size, input int lane);
        logic [63:0] v;
        int nb;
        nb = 1 << size;
        v = rdata >> (8 * lane);
        if (nb < 8) v = v & ((64'd1 << (8 * nb)) - 64'd1);
        return {64'd0, v};
    endfunction

    task automatic model_clear();
        q.delete();
        head_issued = 1'b0;
        err_exp = 1'b0;
        wb_exp_v = 1'b0;
        last_acc = 1'b0;
    endtask

    // Runs at the falling edge: checks what the previous rising edge should have
    // produced, then predicts the effect of the coming rising edge.
    task automatic model_cycle();
        txn_t t;
        int lane;
        chk("busy", 128'(busy), 128'(q.size() != 0));
        chk("err", 128'(err), 128'(err_exp));
        chk("wb_valid", 128'(wb_valid), 128'(wb_exp_v));
        if (wb_exp_v) begin
            chk("wb_select", 128'(wb_select), 128'(wb_exp_sel));
            chk("wb_value", wb_value, wb_exp_val);
        end
        err_exp = 1'b0;
        wb_exp_v = 1'b0;
        last_acc = 1'b0;

        if (mem_rvalid && q.size() != 0 && head_issued) begin
            t = q.pop_front();
            head_issued = 1'b0;
            loads_done++;
            if (t.rd != 7'd0) begin
                wb_exp_v = 1'b1;
                wb_exp_sel = t.rd;
                wb_exp_val = exp_load(mem_rdata, t.size, int'(t.addr[2:0]));
            end
        end

        if (mem_valid) begin
            if (q.size() == 0 || head_issued) begin
                chk_cnt++;
                $display("FAIL mem_valid: got 1 with no command pending, want 0");
            end else begin
                t = q[0];
                lane = int'(t.addr[2:0]);
                chk("mem_we", 128'(mem_we), 128'(!t.load));
                chk("mem_addr", 128'(mem_addr), 128'(t.addr - AW'(lane)));
                if (!t.load) begin
                    chk("mem_wmask", 128'(mem_wmask), 128'(exp_mask(t.size, lane)));
                    chk("mem_wdata", 128'(mem_wdata), 128'(exp_wd(t.wdata, lane)));
                end
                if (mem_ready) begin
                    if (t.load) head_issued = 1'b1;
                    else begin
                        void'(q.pop_front());
                        stores_done++;
                    end
                end
            end
        end

        if (req_valid && req_ready) begin
            last_acc = 1'b1;
            t.load = req_load;
            t.size = req_size;
            t.addr = req_addr;
            t.rd = req_rd;
            t.wdata = req_wdata;
            if (is_misaligned(req_size, req_addr)) err_exp = 1'b1;
            else q.push_back(t);
        end
    endtask

    task automatic drive_mem();
        case (mem_mode)
            0: begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rvalid = head_issued ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
                mem_rdata = {$urandom, $urandom};
            end
            1: begin
                mem_ready = 1'b1;
                mem_rvalid = head_issued;
                mem_rdata = dir_rdata;
            end
            2: begin
                mem_ready = 1'b0;
                mem_rvalid = 1'b0;
            end
            3: begin
                mem_ready = 1'b1;
                mem_rvalid = 1'b0;
            end
            default: begin
                mem_ready = 1'b0;
                mem_rvalid = 1'b1;
                mem_rdata = {$urandom, $urandom};
            end
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        drive_mem();
    endtask

    task automatic run_vec(input vec_t v, input int i);
        int cmd_step, wb_step, wb_cnt, err_cnt;
        logic [AW-1:0] c_addr;
        logic c_we;
        logic [7:0] c_mask;
        logic [63:0] c_wdata;
        logic [6:0] w_sel;
        logic [127:0] w_val;
        cmd_step = -1; wb_step = -1; wb_cnt = 0; err_cnt = 0;
        c_addr = '0; c_we = 1'b0; c_mask = '0; c_wdata = '0; w_sel = '0; w_val = '0;
        mem_mode = 1;
        dir_rdata = v.rdata;
        drive_mem();
        req_valid = 1'b1;
        req_load = v.load;
        req_size = v.size;
        req_addr = v.addr;
        req_rd = v.rd;
        req_wdata = v.wdata;
        step();
        req_valid = 1'b0;
        for (int s = 1; s <= 12; s++) begin
            if (mem_valid && cmd_step < 0) begin
                cmd_step = s;
                c_addr = mem_addr;
                c_we = mem_we;
                c_mask = mem_wmask;
                c_wdata = mem_wdata;
            end
            if (wb_valid) begin
                wb_cnt++;
                wb_step = s;
                w_sel = wb_select;
                w_val = wb_value;
            end
            if (err) err_cnt++;
            step();
        end
        chk($sformatf("v%0d_err", i), 128'(err_cnt), 128'(v.exp_err));
        chk($sformatf("v%0d_cmd_seen", i), 128'(cmd_step >= 0), 128'(!v.exp_err));
        if (cmd_step >= 0) begin
            chk($sformatf("v%0d_mem_addr", i), 128'(c_addr), 128'(v.exp_maddr));
            chk($sformatf("v%0d_mem_we", i), 128'(c_we), 128'(v.exp_we));
            if (!v.load) begin
                chk($sformatf("v%0d_mem_wmask", i), 128'(c_mask), 128'(v.exp_wmask));
                chk($sformatf("v%0d_mem_wdata", i), 128'(c_wdata), 128'(v.exp_wdata));
            end
        end
        chk($sformatf("v%0d_wb_count", i), 128'(wb_cnt), 128'(v.exp_wb));
        if (wb_cnt != 0) begin
            chk($sformatf("v%0d_wb_select", i), 128'(w_sel), 128'(v.rd));
            chk($sformatf("v%0d_wb_value", i), w_val, v.exp_value);
            if (cmd_step >= 0)
                chk($sformatf("v%0d_latency", i), 128'(wb_step - cmd_step), 128'(2));
        end
        chk($sformatf("v%0d_idle", i), 128'(busy), 128'(0));
    endtask

    task automatic rand_req();
        req_valid = ($urandom_range(0, 2) != 0);
        req_load = 1'($urandom_range(0, 1));
        req_size = 2'($urandom_range(0, 3));
        req_addr = AW'({$urandom, $urandom});
        if ($urandom_range(0, 4) != 0) req_addr = req_addr & ~(AW'((1 << req_size) - 1));
        req_rd = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom);
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_mem_valid"}, 128'(mem_valid), 128'(0));
        chk({tag, "_mem_we"}, 128'(mem_we), 128'(0));
        chk({tag, "_mem_addr"}, 128'(mem_addr), 128'(0));
        chk({tag, "_mem_wdata"}, 128'(mem_wdata), 128'(0));
        chk({tag, "_mem_wmask"}, 128'(mem_wmask), 128'(0));
        chk({tag, "_wb_valid"}, 128'(wb_valid), 128'(0));
        chk({tag, "_wb_select"}, 128'(wb_select), 128'(0));
        chk({tag, "_wb_value"}, wb_value, 128'(0));
        chk({tag, "_err"}, 128'(err), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_acc, base_done, guard, wb_seen;

        //        load  size  addr            rd     wdata                                     rdata                  err   maddr           we    wmask  wdata                  wb    value
        vecs[0]  = '{1'b1, 2'd3, 36'h100,        7'd5,   128'd0,                                   64'h1122334455667788, 1'b0, 36'h100,        1'b0, 8'h00, 64'h0,                 1'b1, 128'h1122334455667788};
        vecs[1]  = '{1'b1, 2'd0, 36'h103,        7'd9,   128'd0,                                   64'h1122334455667788, 1'b0, 36'h100,        1'b0, 8'h00, 64'h0,                 1'b1, 128'h55};
        vecs[2]  = '{1'b0, 2'd1, 36'h206,        7'd0,   128'hBEEF,                                64'h0,                1'b0, 36'h200,        1'b1, 8'hC0, 64'hBEEF000000000000,  1'b0, 128'h0};
        vecs[3]  = '{1'b1, 2'd2, 36'h101,        7'd6,   128'd0,                                   64'h0,                1'b1, 36'h0,          1'b0, 8'h00, 64'h0,                 1'b0, 128'h0};
        vecs[4]  = '{1'b1, 2'd3, 36'h108,        7'd0,   128'd0,                                   64'hCAFEF00DCAFEF00D, 1'b0, 36'h108,        1'b0, 8'h00, 64'h0,                 1'b0, 128'h0};
        vecs[5]  = '{1'b1, 2'd2, 36'h10C,        7'd127, 128'd0,                                   64'hAABBCCDD11223344, 1'b0, 36'h108,        1'b0, 8'h00, 64'h0,                 1'b1, 128'hAABBCCDD};
        vecs[6]  = '{1'b0, 2'd0, 36'h3FF,        7'd0,   128'hA5,                                  64'h0,                1'b0, 36'h3F8,        1'b1, 8'h80, 64'hA500000000000000,  1'b0, 128'h0};
        vecs[7]  = '{1'b0, 2'd3, 36'h400,        7'd0,   128'hDEADBEEFCAFEF00D0123456789ABCDEF,    64'h0,                1'b0, 36'h400,        1'b1, 8'hFF, 64'h0123456789ABCDEF,  1'b0, 128'h0};
        vecs[8]  = '{1'b0, 2'd3, 36'h404,        7'd0,   128'h1234,                                64'h0,                1'b1, 36'h0,          1'b0, 8'h00, 64'h0,                 1'b0, 128'h0};
        vecs[9]  = '{1'b1, 2'd1, 36'hFFFFFFFFE,  7'd3,   128'd0,                                   64'hBEEF000000000000, 1'b0, 36'hFFFFFFFF8,  1'b0, 8'h00, 64'h0,                 1'b1, 128'hBEEF};
        vecs[10] = '{1'b0, 2'd2, 36'h2FC,        7'd0,   128'h12345678,                            64'h0,                1'b0, 36'h2F8,        1'b1, 8'hF0, 64'h1234567800000000,  1'b0, 128'h0};

        rst = 1'b0;
        req_valid = 1'b0; req_load = 1'b0; req_size = '0; req_addr = '0; req_rd = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #3;
        check_outputs_zero("reset");
        #10 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_req_ready", 128'(req_ready), 128'(1));

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Memory stalled: six back-to-back stores, one in flight plus a full queue.
        mem_mode = 2;
        drive_mem();
        n_acc = 0;
        base_done = stores_done;
        for (int c = 0; c < 10 && n_acc < 6; c++) begin
            req_valid = 1'b1; req_load = 1'b0; req_size = 2'd3; req_rd = 7'd0;
            req_addr = AW'(36'h1000 + 8 * n_acc);
            req_wdata = {64'hFFFFFFFFFFFFFFFF, 64'(n_acc + 1) * 64'h1111};
            step();
            if (last_acc) n_acc++;
        end
        chk("bp_accepted", 128'(n_acc), 128'(5));
        chk("bp_req_ready", 128'(req_ready), 128'(0));
        chk("bp_mem_valid", 128'(mem_valid), 128'(1));
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_stall_addr", 128'(mem_addr), 128'(36'h1000));
            chk("bp_stall_wdata", 128'(mem_wdata), 128'(64'h1111));
            chk("bp_stall_ready", 128'(req_ready), 128'(0));
        end
        mem_mode = 1;
        drive_mem();
        for (int g = 0; g < 40 && (n_acc < 6 || q.size() != 0); g++) begin
            step();
            if (last_acc) begin
                n_acc++;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        chk("bp_all_accepted", 128'(n_acc), 128'(6));
        chk("bp_stores_done", 128'(stores_done - base_done), 128'(6));
        chk("bp_idle", 128'(busy), 128'(0));

        // Reset pulled while a load waits for its read data.
        mem_mode = 3;
        drive_mem();
        req_valid = 1'b1; req_load = 1'b1; req_size = 2'd3; req_addr = 36'h500; req_rd = 7'd4; req_wdata = '0;
        step();
        req_valid = 1'b0;
        guard = 0;
        while (!head_issued && guard < 20) begin
            step();
            guard++;
        end
        chk("rst_wait_reached", 128'(head_issued), 128'(1));
        rst = 1'b0;
        #1;
        check_outputs_zero("midrst");
        model_clear();
        mem_mode = 4;
        drive_mem();
        step();
        step();
        #2 rst = 1'b1;
        wb_seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (wb_valid) wb_seen++;
        end
        chk("rst_no_wb", 128'(wb_seen), 128'(0));
        chk("rst_idle", 128'(busy), 128'(0));

        // Randomized traffic with random memory ready/response timing.
        mem_mode = 0;
        drive_mem();
        for (int c = 0; c < 3000; c++) begin
            rand_req();
            step();
        end
        req_valid = 1'b0;
        mem_mode = 1;
        drive_mem();
        for (int g = 0; g < 100 && (q.size() != 0 || busy); g++) step();
        step();
        chk("drain_empty", 128'(q.size()), 128'(0));
        chk("drain_idle", 128'(busy), 128'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
